memaccess: RTL
==============

Name: memaccess

Overview:
- Pipeline stage directly downstream of `execute`. Consumes its registered instruction bundle.
- Performs loads over a variable-latency request/grant/response data-memory read port. Aligns and extends load data, then emits one writeback record per instruction.
- Non-load instructions pass `result_i` through with one cycle of latency.
- Stores are not handled here; `execute` issues them.

Parameters:
- MISALIGN_FILL, 32'hFFFFFFFF: writeback value for misaligned or illegal-funct3 loads.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  upstream bundle valid
- ready_o  out  1  stage can accept a bundle this cycle
- pc_i  in  32  instruction PC
- inst_i  in  32  instruction word
- r0data_i  in  32  rs1 value (load base)
- result_i  in  32  ALU/link result from `execute`
- valid_ro  out  1  writeback record valid
- ready_i  in  1  downstream accepts the record
- pc_ro  out  32  registered PC
- inst_ro  out  32  registered instruction
- wbdata_ro  out  32  value to write to rd
- wbenable_ro  out  1  rd write required (rd!=0 and opcode is OP, OPIMM, LUI, AUIPC, JAL, JALR or LOAD)
- misalign_ro  out  1  load was misaligned or had an illegal funct3
- dmem_req_o  out  1  read request, registered
- dmem_addr_o  out  32  word-aligned read address, registered
- dmem_gnt_i  in  1  memory accepted the request
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data, little-endian word

Behaviour:
- Reset (synchronous): every output register clears to 0 (valid_ro, pc_ro, inst_ro, wbdata_ro, wbenable_ro, misalign_ro, dmem_req_o, dmem_addr_o). State goes to IDLE.
- cke = ~valid_ro | ready_i.
- ready_o = (state==IDLE) & cke. It is combinational.
- Accept occurs when valid_i & ready_o.
- States are IDLE, REQ and WAIT.
- IDLE, accept of a non-load:
  - next cycle: valid_ro=1, pc/inst registered, wbdata_ro=result_i, wbenable per rule, misalign_ro=0.
- IDLE, accept of a load:
  - Compute addr = r0data_i + sign-extended inst[31:20].
  - Latch the following into internal registers: pc, inst, addr[1:0], funct3.
  - Error check: the load is in error if any of these holds:
    - funct3 is 3, 6 or 7;
    - funct3 is LH or LHU and addr[0]=1;
    - funct3 is LW and addr[1:0]!=0.
  - Error load: no memory request. Next cycle valid_ro=1, wbdata_ro=MISALIGN_FILL, misalign_ro=1, wbenable_ro=0. State stays IDLE.
  - Legal load:
    - dmem_req_o<=1 and dmem_addr_o<={addr[31:2],2'b00}.
    - valid_ro<=0 (bubble). State goes to REQ.
- IDLE with valid_ro=1 and ~ready_i: all output registers hold and ready_o=0.
- REQ:
  - dmem_req_o and dmem_addr_o are held stable until dmem_gnt_i=1.
  - On grant: dmem_req_o<=0 and state goes to WAIT.
  - dmem_rvalid_i is ignored in REQ.
- WAIT:
  - On dmem_rvalid_i, select the lane from the latched addr[1:0]:
    - LB/LBU use byte addr[1:0]; LB sign-extends, LBU zero-extends.
    - LH/LHU use halfword addr[1]; LH sign-extends, LHU zero-extends.
    - LW uses the full word.
  - Register the result into wbdata_ro, set valid_ro=1 and misalign_ro=0, and return to IDLE.
  - valid_ro is always 0 on entry to WAIT, so the output slot is free.
- Latency:
  - Non-load and error load: 1 cycle from accept to valid_ro.
  - Legal load with grant and rvalid on the earliest cycles: 3 cycles. It stretches with each stalled grant or response cycle.
- Memory contract: dmem_rvalid_i is asserted no earlier than the cycle after the grant. There is exactly one response per grant.
- dmem_rvalid_i in IDLE or REQ is ignored. This covers stale responses after reset.
- Reset mid-operation (REQ/WAIT): return to IDLE, deassert dmem_req_o, clear valid_ro. An outstanding response is dropped.
- Arithmetic: address add is 32-bit wrap-around.

Decomposition:
- Opcode, funct3 (LB/LH/LW/LBU/LHU) and instruction-field bit ranges come from the shared opcode/instruction definition headers. Add the state encoding (IDLE=0, REQ=1, WAIT=2) to that shared header.
- One combinational sub-module, `load_align`: inputs rdata[31:0], offset[1:0], funct3[2:0]; output data[31:0].

Test Plan:
- ADDI bundle (result_i=32'h00000005, rd=3), ready_i=1 -> next cycle valid_ro=1, wbdata_ro=5, wbenable_ro=1, misalign_ro=0.
- LW, r0data_i=32'h100, imm=8, grant same cycle as REQ, rdata=32'hDEADBEEF one cycle later:
  - required: dmem_addr_o=32'h108;
  - required: valid_ro 3 cycles after accept with wbdata_ro=32'hDEADBEEF;
  - required: ready_o=0 throughout REQ and WAIT.
- LB at addr 32'h203 with rdata=32'h80FF7F01 -> wbdata_ro=32'hFFFFFF80. Same for LBU -> 32'h00000080. LHU at addr 32'h202 -> 32'h000080FF.
- LW at addr 32'h102 -> dmem_req_o never asserts; next cycle valid_ro=1, wbdata_ro=32'hFFFFFFFF, misalign_ro=1, wbenable_ro=0.
- Output stall: valid_ro=1 with ready_i=0 for 4 cycles -> ready_o=0 and outputs stable. Grant held off 3 cycles during a load -> dmem_req_o and dmem_addr_o stable.
- rst pulsed during WAIT, then dmem_rvalid_i=1 arrives -> state IDLE, valid_ro=0, no record emitted. Next ADDI is processed normally.

Source files
------------

// File: rtl/memaccess_pkg.sv
// Shared opcode / instruction-field definitions for the memaccess stage, plus the
// memaccess FSM state encoding.
//   - RV32 major opcodes and load funct3 codes
//   - instruction field extractors (opcode, rd, funct3, I-type immediate)
//   - writes_rd(): opcode classes that write a destination register
package memaccess_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [2:0] inst_funct3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    function automatic logic [31:0] inst_imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // rd is written only for these opcode classes, and never for x0.
    function automatic logic writes_rd(input logic [31:0] inst);
        logic cls;
        unique case (inst_opcode(inst))
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: cls = 1'b1;
            default:                     cls = 1'b0;
        endcase
        return cls && (inst_rd(inst) != 5'd0);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte / halfword lane of a little-endian memory word
// and sign- or zero-extends it according to the load funct3.
//   rdata_i  : raw 32-bit word from data memory
//   offset_i : byte offset of the load address within the word
//   funct3_i : load width / signedness
//   data_o   : aligned, extended value for rd
module load_align
    import memaccess_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        unique case (offset_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h000000, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0000, half_sel};
            // LW and the illegal codes (which never reach memory) take the full word.
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memaccess.sv
// Memory-access pipeline stage. Non-loads pass result_i through with one cycle of
// latency; loads issue a request/grant/response read, align the returned word and
// emit one writeback record. Misaligned or illegal-funct3 loads skip memory and
// write back MISALIGN_FILL with misalign_ro set.
//   clk, rst            : clock, synchronous active-high reset
//   valid_i / ready_o   : upstream bundle handshake (pc_i, inst_i, r0data_i, result_i)
//   valid_ro / ready_i  : downstream writeback record handshake
//   pc_ro, inst_ro      : registered instruction identity
//   wbdata_ro           : rd value; wbenable_ro : rd write required
//   misalign_ro         : load was misaligned or illegal
//   dmem_*              : data-memory read port
module memaccess
    import memaccess_pkg::*;
#(
    parameter logic [31:0] MISALIGN_FILL = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] r0data_i,
    input  logic [31:0] result_i,
    output logic        valid_ro,
    input  logic        ready_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro,
    output logic [31:0] wbdata_ro,
    output logic        wbenable_ro,
    output logic        misalign_ro,
    output logic        dmem_req_o,
    output logic [31:0] dmem_addr_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    state_e state_q, state_d;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        wben_q, wben_d;
    logic        mis_q, mis_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    // Context of the in-flight load, held until its response arrives.
    logic [31:0] ld_pc_q, ld_pc_d;
    logic [31:0] ld_inst_q, ld_inst_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [2:0]  ld_f3_q, ld_f3_d;

    logic        cke;
    logic        accept;
    logic        is_load;
    logic [31:0] ld_addr;
    logic [2:0]  f3_in;
    logic        ld_err;
    logic [31:0] align_data;

    assign cke     = ~valid_q | ready_i;
    assign ready_o = (state_q == StIdle) & cke;
    assign accept  = valid_i & ready_o;
    assign is_load = (inst_opcode(inst_i) == OPC_LOAD);
    assign ld_addr = r0data_i + inst_imm_i(inst_i);
    assign f3_in   = inst_funct3(inst_i);

    always_comb begin
        ld_err = 1'b0;
        case (f3_in)
            F3_LB, F3_LBU: ld_err = 1'b0;
            F3_LH, F3_LHU: ld_err = ld_addr[0];
            F3_LW:         ld_err = (ld_addr[1:0] != 2'b00);
            default:       ld_err = 1'b1;
        endcase
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .offset_i (ld_off_q),
        .funct3_i (ld_f3_q),
        .data_o   (align_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && is_load && !ld_err) state_d = StReq;
            StReq:  if (dmem_gnt_i) state_d = StWait;
            StWait: if (dmem_rvalid_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        wbdata_d  = wbdata_q;
        wben_d    = wben_q;
        mis_d     = mis_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ld_pc_d   = ld_pc_q;
        ld_inst_d = ld_inst_q;
        ld_off_d  = ld_off_q;
        ld_f3_d   = ld_f3_q;
        unique case (state_q)
            StIdle: begin
                if (cke) begin
                    // Any held record has been taken (or there was none).
                    valid_d = 1'b0;
                    if (accept) begin
                        if (!is_load) begin
                            valid_d  = 1'b1;
                            pc_d     = pc_i;
                            inst_d   = inst_i;
                            wbdata_d = result_i;
                            wben_d   = writes_rd(inst_i);
                            mis_d    = 1'b0;
                        end else if (ld_err) begin
                            valid_d  = 1'b1;
                            pc_d     = pc_i;
                            inst_d   = inst_i;
                            wbdata_d = MISALIGN_FILL;
                            wben_d   = 1'b0;
                            mis_d    = 1'b1;
                        end else begin
                            req_d     = 1'b1;
                            addr_d    = {ld_addr[31:2], 2'b00};
                            ld_pc_d   = pc_i;
                            ld_inst_d = inst_i;
                            ld_off_d  = ld_addr[1:0];
                            ld_f3_d   = f3_in;
                        end
                    end
                end
            end
            StReq: begin
                if (dmem_gnt_i) req_d = 1'b0;
            end
            StWait: begin
                // valid_q is always 0 here, so the output slot is free.
                if (dmem_rvalid_i) begin
                    valid_d  = 1'b1;
                    pc_d     = ld_pc_q;
                    inst_d   = ld_inst_q;
                    wbdata_d = align_data;
                    wben_d   = writes_rd(ld_inst_q);
                    mis_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= 32'h0;
            inst_q    <= 32'h0;
            wbdata_q  <= 32'h0;
            wben_q    <= 1'b0;
            mis_q     <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= 32'h0;
            ld_pc_q   <= 32'h0;
            ld_inst_q <= 32'h0;
            ld_off_q  <= 2'd0;
            ld_f3_q   <= 3'd0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            wbdata_q  <= wbdata_d;
            wben_q    <= wben_d;
            mis_q     <= mis_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ld_pc_q   <= ld_pc_d;
            ld_inst_q <= ld_inst_d;
            ld_off_q  <= ld_off_d;
            ld_f3_q   <= ld_f3_d;
        end
    end

    assign valid_ro    = valid_q;
    assign pc_ro       = pc_q;
    assign inst_ro     = inst_q;
    assign wbdata_ro   = wbdata_q;
    assign wbenable_ro = wben_q;
    assign misalign_ro = mis_q;
    assign dmem_req_o  = req_q;
    assign dmem_addr_o = addr_q;

endmodule
